// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: state encoding and
// counter sizing.
package mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // One extra bit so the counter can reach WIDTH without wrapping.
  function automatic int CNT_W(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mul_seq_step.sv
// One shift-add iteration: conditionally add the multiplicand into the high
// half, then shift the {carry, high, low} accumulator right by one.
module mul_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = acc_lo_i[0] ? ({1'b0, acc_hi_i} + {1'b0, mcand_i}) : {1'b0, acc_hi_i};
    acc_hi_o = sum[WIDTH:1];
    acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative unsigned multiplier: one operand pair in, WIDTH shift-add steps,
// full-width product out, each side a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds valid and data stable until that edge, and
// ready may not depend combinationally on valid.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);

  localparam int             CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e                state_q;
  logic [WIDTH-1:0]      mcand_q;
  logic [WIDTH-1:0]      acc_hi_q;
  logic [WIDTH-1:0]      acc_lo_q;
  logic [WIDTH-1:0]      acc_hi_d;
  logic [WIDTH-1:0]      acc_lo_d;
  logic [CW-1:0]         cnt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic [2*WIDTH-1:0]    product_q;
  logic                  zero_op;

  assign zero_op = ZERO_SKIP && ((in_a == '0) || (in_b == '0));

  mul_seq_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .mcand_i  (mcand_q),
    .acc_hi_o (acc_hi_d),
    .acc_lo_o (acc_lo_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= in_a;
            acc_hi_q   <= '0;
            acc_lo_q   <= in_b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (zero_op) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              product_q   <= '0;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          // Product is published only from the final step, never partially.
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            product_q   <= {acc_hi_d, acc_lo_d};
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and random checks of the sequential multiplier, with a second
// instance built without zero-operand bypass.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b;
  logic [63:0] product;
  logic [1:0]  dbg_state;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [63:0] product0;
  logic [1:0]  dbg_state0;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  mul_seq_ctrl #(.WIDTH(32), .ZERO_SKIP(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .dbg_state_o(dbg_state)
  );

  mul_seq_ctrl #(.WIDTH(32), .ZERO_SKIP(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready0),
    .product(product0), .busy(busy0), .dbg_state_o(dbg_state0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: present operands until accepted, then scramble the inputs
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [63:0] prod, output int lat,
                       output bit rdy_seen, output bit stable);
    logic [63:0] a64, b64;
    a64 = {32'd0, a}; b64 = {32'd0, b};
    start_op(a, b);
    exp_q.push_back(a64 * b64);
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    prod = product; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (product !== prod || !out_valid || in_ready) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (exp_q.size() > 0) check("sb_product", prod, exp_q.pop_front());
  endtask

  logic [63:0] p;
  int          lat;
  bit          rs, st;
  logic [31:0] ra, rb;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 3 * 5
    do_op(32'd3, 32'd5, 0, p, lat, rs, st);
    check("t1_lat", lat, 33);
    check("t1_prod", p, 64'd15);
    check("t1_ready_busy", rs, 0);

    // max * max
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, p, lat, rs, st);
    check("t2_lat", lat, 33);
    check("t2_prod", p, 64'hFFFF_FFFE_0000_0001);

    // zero bypass
    do_op(32'h1234_5678, 32'd0, 0, p, lat, rs, st);
    check("t3_lat", lat, 1);
    check("t3_prod", p, 64'd0);

    // same operands without bypass
    in_a = 32'h1234_5678; in_b = 32'd0; in_valid0 = 1'b1;
    @(negedge clk);
    check("t3b_ready", in_ready0, 1);
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_a = $urandom; in_b = $urandom;
    lat = 1;
    while (!out_valid0 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t3b_lat", lat, 33);
    check("t3b_prod", product0, 64'd0);
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    check("t3b_idle", out_valid0, 0);

    // back-pressure in DONE
    do_op(32'h8000_0000, 32'd2, 10, p, lat, rs, st);
    check("t4_prod", p, 64'h1_0000_0000);
    check("t4_stable", st, 1);
    check("t4_out_valid", out_valid, 0);
    check("t4_in_ready", in_ready, 1);
    check("t4_keep_prod", product, 64'h1_0000_0000);

    // reset mid-run
    start_op(32'd7, 32'd9);
    repeat (11) @(posedge clk);
    #2;
    check("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'd6, 32'd7, 0, p, lat, rs, st);
    check("t5_prod", p, 64'd42);

    // random
    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      rb = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_op(ra, rb, $urandom_range(0, 3), p, lat, rs, st);
      check("rnd_lat", lat, (ra == 0 || rb == 0) ? 33'd1 : 33'd33);
      check("rnd_no_accept_busy", {rs, ~st}, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
